// File: rtl/store_checker_pkg.sv
// Shared types for the store checker: FSM state encoding, LED bit positions
// and a small popcount helper used to build the LED status byte.
package store_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int LED_PASS    = 0;
  localparam int LED_FAIL    = 1;
  localparam int LED_TIMEOUT = 2;
  localparam int LED_RUNNING = 3;
  localparam int LED_CNT_LSB = 4;

  // Only the low four bits of the count are shown on the LEDs, so the
  // result wraps modulo 16.
  function automatic logic [3:0] popcount_lo4(input logic [15:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/store_checker_entry.sv
// One expected-store table slot: holds {valid, addr, data, matched} and flags
// whether the store on the bus hits it with equal or with unequal data.
module store_checker_entry #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              clear_match,
  input  logic              set_match,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              valid,
  output logic              matched,
  output logic              hit,
  output logic              mismatch
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              addr_eq;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid   <= 1'b0;
      matched <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (we) begin
        valid  <= 1'b1;
        addr_q <= cfg_addr;
        data_q <= cfg_data;
      end
      if (clear_match)           matched <= 1'b0;
      else if (set_match && hit) matched <= 1'b1;
    end
  end

  assign addr_eq  = valid && mem_write && (data_adr == addr_q);
  assign hit      = addr_eq && (write_data == data_q);
  assign mismatch = addr_eq && (write_data != data_q);

endmodule

// File: rtl/store_checker.sv
// Watches CPU stores against a table of expected {addr,data} pairs and reports
// pass / fail / timeout. Define STORE_CHECKER_CAPTURE_EN to latch the offending store.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int N_CHECKS       = 3,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IDX_W = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   data_adr,
  input  logic [DATA_W-1:0]   write_data,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [IDX_W-1:0]    fail_idx,
  output logic [N_CHECKS-1:0] match_mask,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [7:0]          led,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_data,
  output logic [2:0]          state_dbg
);

  state_t              state, state_next;
  logic [N_CHECKS-1:0] valid_vec, hit_vec, mis_vec;
  logic                running, start_run, any_mis, all_done, set_match;
  logic [CNT_W-1:0]    cnt_next;
  logic [IDX_W-1:0]    mis_low;

  assign running   = (state == S_RUN);
  assign start_run = start && (state != S_RUN);
  assign any_mis   = running && (|mis_vec);
  // A mismatch anywhere in the cycle suppresses the matches it would otherwise record.
  assign set_match = running && !any_mis;
  assign all_done  = &(match_mask | hit_vec | ~valid_vec);
  assign cnt_next  = cycle_count + CNT_W'(1);
  assign state_dbg = state;

  for (genvar i = 0; i < N_CHECKS; i++) begin : g_entry
    store_checker_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_entry (
      .clk        (clk),
      .reset      (reset),
      .we         (cfg_we && (state == S_IDLE) && (cfg_idx == IDX_W'(i))),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .clear_match(start_run),
      .set_match  (set_match),
      .mem_write  (mem_write),
      .data_adr   (data_adr),
      .write_data (write_data),
      .valid      (valid_vec[i]),
      .matched    (match_mask[i]),
      .hit        (hit_vec[i]),
      .mismatch   (mis_vec[i])
    );
  end

  always_comb begin
    mis_low = '0;
    for (int i = N_CHECKS - 1; i >= 0; i--)
      if (mis_vec[i]) mis_low = IDX_W'(i);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN: begin
        if (any_mis)                                 state_next = S_FAIL;
        else if (all_done)                           state_next = S_PASS;
        else if (cnt_next == CNT_W'(TIMEOUT_CYCLES)) state_next = S_TIMEOUT;
      end
      default: if (start) state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
      fail_idx    <= '0;
    end else if (start_run) begin
      cycle_count <= '0;
      fail_idx    <= '0;
    end else if (running) begin
      cycle_count <= cnt_next;
      if (any_mis) fail_idx <= mis_low;
    end
  end

  always_comb begin
    pass    = (state == S_PASS);
    fail    = (state == S_FAIL);
    timeout = (state == S_TIMEOUT);
    done    = pass || fail || timeout;
    led     = '0;
    led[LED_PASS]            = pass;
    led[LED_FAIL]            = fail;
    led[LED_TIMEOUT]         = timeout;
    led[LED_RUNNING]         = running;
    led[LED_CNT_LSB +: 4]    = popcount_lo4(16'(match_mask));
  end

`ifdef STORE_CHECKER_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!reset || start_run) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (any_mis) begin
      fail_addr <= data_adr;
      fail_data <= write_data;
    end
  end
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker (N_CHECKS=3, TIMEOUT_CYCLES=20); honours
// STORE_CHECKER_CAPTURE_EN for the captured offending-store values.
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0, cfg_data = '0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = '0, write_data = '0;
  logic        done, pass, fail, timeout;
  logic [1:0]  fail_idx;
  logic [2:0]  match_mask;
  logic [4:0]  cycle_count;
  logic [7:0]  led;
  logic [31:0] fail_addr, fail_data;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

`ifdef STORE_CHECKER_CAPTURE_EN
  localparam logic [31:0] EXP_FAIL_ADDR = 32'd12;
  localparam logic [31:0] EXP_FAIL_DATA = 32'd6;
`else
  localparam logic [31:0] EXP_FAIL_ADDR = 32'd0;
  localparam logic [31:0] EXP_FAIL_DATA = 32'd0;
`endif

  store_checker #(.N_CHECKS(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .fail_idx(fail_idx), .match_mask(match_mask),
    .cycle_count(cycle_count), .led(led), .fail_addr(fail_addr),
    .fail_data(fail_data), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; mem_write = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // drivers
  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; data_adr = a; write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_default();
    cfg_write(2'd0, 32'd8, 32'd13);
    cfg_write(2'd1, 32'd12, 32'd7);
    cfg_write(2'd2, 32'd16, 32'd30);
    cfg_write(2'd3, 32'd8, 32'd99);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    if ({done, pass, fail, timeout, fail_idx, match_mask, cycle_count, led, state_dbg} !== 28'd0) begin
      $display("FAIL reset_outputs: got %h expected 0", {done, pass, fail, timeout, fail_idx, match_mask, cycle_count, led, state_dbg}); n_errors++;
    end
    n_checks++;
    if ({fail_addr, fail_data} !== 64'd0) begin
      $display("FAIL reset_capture: got %h expected 0", {fail_addr, fail_data}); n_errors++;
    end
    n_checks++;
    reset = 1'b1;
  endtask

  task automatic test_pass();
    load_default();
    pulse_start();
    if (state_dbg !== 3'd1 || led !== 8'h08) begin
      $display("FAIL run_entry: got state %0d led %h expected 1 08", state_dbg, led); n_errors++;
    end
    n_checks++;
    do_store(32'd8, 32'd13);
    if (match_mask !== 3'b001) begin
      $display("FAIL first_match: got %b expected 001", match_mask); n_errors++;
    end
    n_checks++;
    do_store(32'd12, 32'd7);
    do_store(32'd16, 32'd30);
    if (pass !== 1'b1 || done !== 1'b1 || match_mask !== 3'b111 || led !== 8'h31) begin
      $display("FAIL pass_result: got pass %b done %b mask %b led %h expected 1 1 111 31", pass, done, match_mask, led); n_errors++;
    end
    n_checks++;
    tick();
    if (pass !== 1'b1 || cycle_count !== 5'd3) begin
      $display("FAIL pass_hold: got pass %b count %0d expected 1 3", pass, cycle_count); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_fail();
    pulse_start();
    if (match_mask !== 3'b000 || cycle_count !== 5'd0 || pass !== 1'b0) begin
      $display("FAIL restart_clear: got mask %b count %0d pass %b expected 000 0 0", match_mask, cycle_count, pass); n_errors++;
    end
    n_checks++;
    mem_write = 1'b0; data_adr = 32'd12; write_data = 32'd6;
    tick();
    do_store(32'd100, 32'd6);
    if (state_dbg !== 3'd1) begin
      $display("FAIL ignored_stores: got state %0d expected 1", state_dbg); n_errors++;
    end
    n_checks++;
    do_store(32'd12, 32'd6);
    if (fail !== 1'b1 || fail_idx !== 2'd1 || led !== 8'h02) begin
      $display("FAIL fail_result: got fail %b idx %0d led %h expected 1 1 02", fail, fail_idx, led); n_errors++;
    end
    n_checks++;
    if (fail_addr !== EXP_FAIL_ADDR || fail_data !== EXP_FAIL_DATA) begin
      $display("FAIL fail_capture: got %0d %0d expected %0d %0d", fail_addr, fail_data, EXP_FAIL_ADDR, EXP_FAIL_DATA); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_timeout();
    int k;
    pulse_start();
    if (fail !== 1'b0 || fail_idx !== 2'd0 || fail_addr !== 32'd0) begin
      $display("FAIL restart_after_fail: got fail %b idx %0d addr %0d expected 0 0 0", fail, fail_idx, fail_addr); n_errors++;
    end
    n_checks++;
    do_store(32'd8, 32'd13);
    do_store(32'd12, 32'd7);
    k = 2;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    if (k !== 20) begin
      $display("FAIL timeout_latency: got %0d cycles expected 20", k); n_errors++;
    end
    n_checks++;
    if (timeout !== 1'b1 || pass !== 1'b0 || cycle_count !== 5'd20 || match_mask !== 3'b011 || led !== 8'h24) begin
      $display("FAIL timeout_result: got to %b pass %b count %0d mask %b led %h expected 1 0 20 011 24", timeout, pass, cycle_count, match_mask, led); n_errors++;
    end
    n_checks++;
    cfg_write(2'd2, 32'd16, 32'd99);
    tick();
    if (timeout !== 1'b1 || cycle_count !== 5'd20) begin
      $display("FAIL timeout_hold: got to %b count %0d expected 1 20", timeout, cycle_count); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_race();
    pulse_start();
    do_store(32'd8, 32'd13);
    do_store(32'd12, 32'd7);
    repeat (17) tick();
    if (state_dbg !== 3'd1 || cycle_count !== 5'd19) begin
      $display("FAIL race_pre: got state %0d count %0d expected 1 19", state_dbg, cycle_count); n_errors++;
    end
    n_checks++;
    do_store(32'd16, 32'd30);
    if (pass !== 1'b1 || timeout !== 1'b0 || cycle_count !== 5'd20 || match_mask !== 3'b111) begin
      $display("FAIL race_pass: got pass %b to %b count %0d mask %b expected 1 0 20 111", pass, timeout, cycle_count, match_mask); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_shared();
    do_reset();
    cfg_write(2'd0, 32'd40, 32'd1);
    cfg_write(2'd1, 32'd40, 32'd1);
    cfg_write(2'd2, 32'd44, 32'd5);
    pulse_start();
    do_store(32'd40, 32'd1);
    if (match_mask !== 3'b011 || state_dbg !== 3'd1) begin
      $display("FAIL shared_match: got mask %b state %0d expected 011 1", match_mask, state_dbg); n_errors++;
    end
    n_checks++;
    do_store(32'd44, 32'd5);
    if (pass !== 1'b1) begin
      $display("FAIL shared_pass: got %b expected 1", pass); n_errors++;
    end
    n_checks++;
    do_reset();
    cfg_write(2'd0, 32'd40, 32'd1);
    cfg_write(2'd1, 32'd40, 32'd2);
    cfg_write(2'd2, 32'd44, 32'd5);
    pulse_start();
    do_store(32'd40, 32'd2);
    if (fail !== 1'b1 || fail_idx !== 2'd0) begin
      $display("FAIL shared_mismatch: got fail %b idx %0d expected 1 0", fail, fail_idx); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_default();
    pulse_start();
    do_store(32'd8, 32'd13);
    if (match_mask !== 3'b001) begin
      $display("FAIL midrun_match: got %b expected 001", match_mask); n_errors++;
    end
    n_checks++;
    reset = 1'b0;
    tick();
    if ({done, pass, fail, timeout, fail_idx, match_mask, cycle_count, led, state_dbg} !== 28'd0) begin
      $display("FAIL midrun_reset: got %h expected 0", {done, pass, fail, timeout, fail_idx, match_mask, cycle_count, led, state_dbg}); n_errors++;
    end
    n_checks++;
    reset = 1'b1;
    pulse_start();
    tick();
    if (pass !== 1'b1 || match_mask !== 3'b000 || led !== 8'h01) begin
      $display("FAIL empty_table_pass: got pass %b mask %b led %h expected 1 000 01", pass, match_mask, led); n_errors++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_race();
    test_shared();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
